wb_forward_pipe: RTL

- Write-back staging pipe on the consumer end of the execution-unit result interface.
- Captures each stage-3 result (wb_data, wb_reg_addr, wb_enable_reg_write) from the Byte and peer units and shifts it through DEPTH staging registers.
- Answers forwarding lookups for the register-fetch stage, youngest match wins.
- Retires the oldest entry to the register table write port.

---
 rtl/wb_forward_pipe_if.sv | 37 +++
 rtl/wb_forward_pipe.sv | 93 +++++++++
 2 files changed

// File: rtl/wb_forward_pipe_if.sv
// Result-bus / forwarding / register-table-write bundle of the write-back pipe.
interface wb_forward_pipe_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 4;

  logic [0:DATA_W-1] wb_data;
  logic [0:ADDR_W-1] wb_reg_addr;
  logic              wb_enable_reg_write;
  logic              branch_is_taken;
  logic [0:ADDR_W-1] fwd_addr_a;
  logic [0:ADDR_W-1] fwd_addr_b;
  logic [0:DATA_W-1] fwd_data_a;
  logic              fwd_hit_a;
  logic [0:DATA_W-1] fwd_data_b;
  logic              fwd_hit_b;
  logic              rf_wr_en;
  logic [0:ADDR_W-1] rf_wr_addr;
  logic [0:DATA_W-1] rf_wr_data;
  logic [CNT_W-1:0]  pending_count;

  // Execution unit / register-fetch side.
  modport master (
    output wb_data, wb_reg_addr, wb_enable_reg_write, branch_is_taken,
    output fwd_addr_a, fwd_addr_b,
    input  fwd_data_a, fwd_hit_a, fwd_data_b, fwd_hit_b,
    input  rf_wr_en, rf_wr_addr, rf_wr_data, pending_count
  );

  // Write-back pipe side.
  modport slave (
    input  wb_data, wb_reg_addr, wb_enable_reg_write, branch_is_taken,
    input  fwd_addr_a, fwd_addr_b,
    output fwd_data_a, fwd_hit_a, fwd_data_b, fwd_hit_b,
    output rf_wr_en, rf_wr_addr, rf_wr_data, pending_count
  );
endinterface

// File: rtl/wb_forward_pipe.sv
// Write-back staging pipe: shifts stage-3 results through DEPTH registers,
// forwards the youngest matching value, and retires the oldest to the register table.
module wb_forward_pipe #(
  parameter int unsigned DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  wb_forward_pipe_if.slave bus
);
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic              valid;
    logic [0:ADDR_W-1] addr;
    logic [0:DATA_W-1] data;
  } entry_t;

  entry_t            stage_q [1:DEPTH];
  logic              rf_en_q;
  logic [0:ADDR_W-1] rf_addr_q;
  logic [0:DATA_W-1] rf_data_q;
  logic [CNT_W-1:0]  pending_q;

  logic              cap_valid_c;
  logic              hit_a_c;
  logic              hit_b_c;
  logic [0:DATA_W-1] data_a_c;
  logic [0:DATA_W-1] data_b_c;

  // A flushed result is captured as an empty slot.
  assign cap_valid_c = bus.wb_enable_reg_write & ~bus.branch_is_taken;

  // Shift pipe, retire register and occupancy counter; no stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
    end else begin
      stage_q[1] <= {cap_valid_c, bus.wb_reg_addr, bus.wb_data};
      for (int i = 2; i <= int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      rf_en_q   <= stage_q[DEPTH].valid;
      rf_addr_q <= stage_q[DEPTH].addr;
      rf_data_q <= stage_q[DEPTH].data;
      pending_q <= pending_q + CNT_W'(cap_valid_c) - CNT_W'(stage_q[DEPTH].valid);
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    hit_a_c  = 1'b0;
    hit_b_c  = 1'b0;
    data_a_c = '0;
    data_b_c = '0;
    for (int i = int'(DEPTH); i >= 1; i--) begin
      if (stage_q[i].valid && (stage_q[i].addr == bus.fwd_addr_a)) begin
        hit_a_c  = 1'b1;
        data_a_c = stage_q[i].data;
      end
      if (stage_q[i].valid && (stage_q[i].addr == bus.fwd_addr_b)) begin
        hit_b_c  = 1'b1;
        data_b_c = stage_q[i].data;
      end
    end
    if (cap_valid_c && (bus.wb_reg_addr == bus.fwd_addr_a)) begin
      hit_a_c  = 1'b1;
      data_a_c = bus.wb_data;
    end
    if (cap_valid_c && (bus.wb_reg_addr == bus.fwd_addr_b)) begin
      hit_b_c  = 1'b1;
      data_b_c = bus.wb_data;
    end
  end

  // Output drive.
  assign bus.fwd_hit_a     = hit_a_c;
  assign bus.fwd_data_a    = data_a_c;
  assign bus.fwd_hit_b     = hit_b_c;
  assign bus.fwd_data_b    = data_b_c;
  assign bus.rf_wr_en      = rf_en_q;
  assign bus.rf_wr_addr    = rf_addr_q;
  assign bus.rf_wr_data    = rf_data_q;
  assign bus.pending_count = pending_q;

endmodule
